// File: rtl/add_sched_pkg.sv
`default_nettype none
// add_sched_pkg: slice width and FSM state type shared by the sliced add scheduler.
package add_sched_pkg;
   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/add_sched_add16_cin.sv
`default_nettype none
// add16_cin: combinational 16-bit ripple-carry adder with carry-in and carry-out.
module add16_cin
   import add_sched_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);
   logic c;

   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule
`default_nettype wire

// File: rtl/add_sched.sv
`default_nettype none
// add_sched: two-channel round-robin scheduler that performs wide additions
// one 16-bit slice per cycle on a single shared adder.
module add_sched
   import add_sched_pkg::*;
#(
   parameter int NSLICE = 2
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [SLICE_W*NSLICE-1:0] req0_a,
   input  logic [SLICE_W*NSLICE-1:0] req0_b,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [SLICE_W*NSLICE-1:0] req1_a,
   input  logic [SLICE_W*NSLICE-1:0] req1_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [SLICE_W*NSLICE-1:0] res_sum,
   output logic                      res_carry,
   output logic                      res_id,
   output logic                      busy
);
   localparam int OW = SLICE_W * NSLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   state_t              state;
   state_t              state_nxt;
   logic [OW-1:0]       a_reg;
   logic [OW-1:0]       b_reg;
   logic [OW-1:0]       sum_reg;
   logic [KW-1:0]       k;
   logic                carry_reg;
   logic                id_reg;
   logic                last_grant;
   logic                grant;
   logic                accept;
   logic [SLICE_W-1:0]  a_slice;
   logic [SLICE_W-1:0]  b_slice;
   logic [SLICE_W-1:0]  add_sum;
   logic                add_cout;

   // On a tie the channel that did not win last time gets the grant.
   always_comb begin
      if (req0_valid && req1_valid) grant = ~last_grant;
      else                          grant = req1_valid;
   end

   assign req0_ready = (state == IDLE) && !grant && req0_valid;
   assign req1_ready = (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (k == KW'(i)) begin
            a_slice = a_reg[i*SLICE_W +: SLICE_W];
            b_slice = b_reg[i*SLICE_W +: SLICE_W];
         end
      end
   end

   add16_cin u_add (
      .a    (a_slice),
      .b    (b_slice),
      .cin  (carry_reg),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = ADD;
         ADD:     if (k == K_LAST)   state_nxt = RESP;
         RESP:    if (res_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         sum_reg    <= '0;
         k          <= '0;
         carry_reg  <= 1'b0;
         id_reg     <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg      <= grant ? req1_a : req0_a;
                  b_reg      <= grant ? req1_b : req0_b;
                  id_reg     <= grant;
                  last_grant <= grant;
                  k          <= '0;
                  carry_reg  <= 1'b0;
               end
            end
            ADD: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (k == KW'(i)) sum_reg[i*SLICE_W +: SLICE_W] <= add_sum;
               end
               carry_reg <= add_cout;
               k         <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end

   assign res_valid = (state == RESP);
   assign res_sum   = sum_reg;
   assign res_carry = carry_reg;
   assign res_id    = id_reg;
   assign busy      = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_add_sched.sv
`default_nettype none
`timescale 1ns/1ps
// tb_add_sched: randomized scoreboard bench for add_sched, plus directed cases.
module tb_add_sched;
   localparam int NS  = 2;
   localparam int OW  = 32;
   localparam int NS4 = 4;
   localparam int OW4 = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [OW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic          res_valid, res_ready, res_carry, res_id, busy;
   logic [OW-1:0] res_sum;

   logic           v4_0, r4_0, v4_1, r4_1, rv4, rr4, c4, id4, busy4;
   logic [OW4-1:0] a4_0, b4_0, a4_1, b4_1, sum4;

   add_sched #(.NSLICE(NS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_carry(res_carry), .res_id(res_id), .busy(busy)
   );

   add_sched #(.NSLICE(NS4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v4_0), .req0_ready(r4_0), .req0_a(a4_0), .req0_b(b4_0),
      .req1_valid(v4_1), .req1_ready(r4_1), .req1_a(a4_1), .req1_b(b4_1),
      .res_valid(rv4), .res_ready(rr4), .res_sum(sum4),
      .res_carry(c4), .res_id(id4), .busy(busy4)
   );

   typedef struct { logic [OW-1:0] sum; logic carry; logic id; } exp_t;
   typedef struct { logic [OW-1:0] a; logic [OW-1:0] b; } req_t;

   exp_t   sb[$];
   req_t   q0[$], q1[$];
   req_t   rq;
   logic   id_log[$];
   int     tests = 0, fails = 0;
   int     cyc = 0, acc_cyc = 0;
   int     p_valid, rr_mode;
   logic   hs0, hs1, m_busy, m_last, prev_rv, g, e0, e1;
   logic [OW-1:0] last_sum;
   logic   last_carry, last_id;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: full-precision sum, low OW bits and the overflow bit.
   function automatic exp_t ref_add(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic id);
      exp_t e;
      logic [OW:0] full;
      full    = {1'b0, a} + {1'b0, b};
      e.sum   = full[OW-1:0];
      e.carry = full[OW];
      e.id    = id;
      return e;
   endfunction

   function automatic logic [OW-1:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return '0;
         default: return $urandom;
      endcase
   endfunction

   task automatic send(input logic ch, input logic [OW-1:0] a, input logic [OW-1:0] b);
      req_t r;
      r.a = a;
      r.b = b;
      if (ch) q1.push_back(r);
      else    q0.push_back(r);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid ||
              sb.size() != 0 || res_valid || m_busy) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= budget) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: timeout after %0d cycles, pending=%0d", n, sb.size());
      end
   endtask

   // Requesters and result consumer: change inputs just after the rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rr_mode == 1)      res_ready = ($urandom_range(0, 2) != 0);
         else if (rr_mode == 0) res_ready = 1'b1;
         if (hs0) begin
            hs0 = 1'b0; req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
         end
         if (hs1) begin
            hs1 = 1'b0; req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
         end
         if (!req0_valid && q0.size() != 0 && $urandom_range(0, 99) < p_valid) begin
            rq = q0.pop_front(); req0_a = rq.a; req0_b = rq.b; req0_valid = 1'b1;
         end
         if (!req1_valid && q1.size() != 0 && $urandom_range(0, 99) < p_valid) begin
            rq = q1.pop_front(); req1_a = rq.a; req1_b = rq.b; req1_valid = 1'b1;
         end
      end
   end

   // Monitor: grant model, scoreboard push on accept, pop/compare on result.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", busy, m_busy);
         if (!m_busy) begin
            g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            e0 = req0_valid && !g;
            e1 = req1_valid && g;
         end else begin
            e0 = 1'b0;
            e1 = 1'b0;
         end
         check("req0_ready", req0_ready, e0);
         check("req1_ready", req1_ready, e1);
         if (req0_valid && req0_ready) begin
            sb.push_back(ref_add(req0_a, req0_b, 1'b0));
            hs0 = 1'b1; m_busy = 1'b1; m_last = 1'b0; acc_cyc = cyc + 1;
         end else if (req1_valid && req1_ready) begin
            sb.push_back(ref_add(req1_a, req1_b, 1'b1));
            hs1 = 1'b1; m_busy = 1'b1; m_last = 1'b1; acc_cyc = cyc + 1;
         end
         if (res_valid) begin
            if (!prev_rv) check("latency", 64'(cyc - acc_cyc), 64'(NS));
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: actual sum=%h required no result", res_sum);
            end else begin
               check("res_sum", res_sum, sb[0].sum);
               check("res_carry", res_carry, sb[0].carry);
               check("res_id", res_id, sb[0].id);
               if (res_ready) begin
                  id_log.push_back(res_id);
                  last_sum = res_sum; last_carry = res_carry; last_id = res_id;
                  void'(sb.pop_front());
                  m_busy = 1'b0;
               end
            end
         end
         prev_rv = res_valid;
      end
   end

   initial begin
      int n;
      logic [0:3] rr_seq;
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      res_ready = 0; rr_mode = 0; p_valid = 100;
      hs0 = 0; hs1 = 0; m_busy = 0; m_last = 1; prev_rv = 0;
      v4_0 = 0; v4_1 = 0; a4_0 = '0; b4_0 = '0; a4_1 = '0; b4_1 = '0; rr4 = 1;
      last_sum = '0; last_carry = 0; last_id = 0;

      #12;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_sum", res_sum, 0);
      check("rst_res_carry", res_carry, 0);
      check("rst_res_id", res_id, 0);
      check("rst_busy", busy, 0);
      check("rst_busy4", busy4, 0);
      @(posedge clk); #3 rst_n = 1'b1;

      // Both channels continuously valid right after reset.
      id_log.delete();
      for (int i = 0; i < 2; i++) begin
         send(1'b0, $urandom, $urandom);
         send(1'b1, $urandom, $urandom);
      end
      wait_idle(200);
      rr_seq = 4'b0101;
      check("rr_count", id_log.size(), 4);
      for (int i = 0; i < 4 && i < id_log.size(); i++) check("rr_seq", id_log[i], rr_seq[i]);

      send(1'b0, 32'h0000_FFFF, 32'h0000_0001);
      wait_idle(100);
      check("dir_carry16_sum", last_sum, 32'h0001_0000);
      check("dir_carry16_carry", last_carry, 0);
      check("dir_carry16_id", last_id, 0);

      send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      wait_idle(100);
      check("dir_wrap_sum", last_sum, 32'h0000_0000);
      check("dir_wrap_carry", last_carry, 1);
      check("dir_wrap_id", last_id, 1);

      // Consumer stalls five cycles with both channels waiting.
      rr_mode = 2; res_ready = 1'b0;
      send(1'b0, 32'h8000_0000, 32'h8000_0000);
      send(1'b1, 32'h0000_0003, 32'h0000_0004);
      n = 0;
      while (!res_valid && n < 50) begin @(negedge clk); n++; end
      check("stall_reached", n < 50, 1);
      repeat (5) @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1", req1_ready, 0);
      check("stall_sum", res_sum, 32'h0000_0000);
      check("stall_carry", res_carry, 1);
      @(posedge clk); #1 res_ready = 1'b1; rr_mode = 0;
      wait_idle(100);

      // Reset in the middle of ADD discards the operation.
      send(1'b0, 32'hDEAD_BEEF, 32'h0000_0001);
      n = 0;
      while (!m_busy && n < 20) begin @(posedge clk); n++; end
      check("abort_accepted", m_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      check("abort_res_valid", res_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_sum", res_sum, 0);
      sb.delete(); m_busy = 0; m_last = 1; prev_rv = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      send(1'b1, 32'h1234_5678, 32'h1111_1111);
      wait_idle(100);
      check("post_abort_sum", last_sum, 32'h2345_6789);
      check("post_abort_carry", last_carry, 0);
      check("post_abort_id", last_id, 1);

      // Randomized traffic with random consumer back-pressure.
      rr_mode = 1; p_valid = 60;
      for (int i = 0; i < 150; i++) send(1'($urandom_range(0, 1)), rand_op(), rand_op());
      wait_idle(5000);
      rr_mode = 0;

      // Four-slice instance: all ones plus one.
      @(posedge clk); #1;
      a4_0 = '1; b4_0 = 64'd1; v4_0 = 1'b1; rr4 = 1'b1;
      @(negedge clk);
      check("n4_ready", r4_0, 1);
      @(posedge clk); #1;
      v4_0 = 1'b0; a4_0 = {$urandom, $urandom};
      for (int i = 0; i <= NS4; i++) begin
         if (i > 0) @(posedge clk);
         @(negedge clk);
         check("n4_res_valid", rv4, (i == NS4));
      end
      check("n4_sum", sum4, 64'd0);
      check("n4_carry", c4, 1);
      check("n4_id", id4, 0);
      @(posedge clk);
      @(negedge clk);
      check("n4_done", rv4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
